// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin, burst-bounded arbiter sharing one data memory between two ports.
// Optional DM_ARB_STATS_EN adds saturating grant/contention counters.
module dm_arbiter #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4,
   parameter int STAT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wd,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rd
`ifdef DM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] gcnt0,
   output logic [STAT_W-1:0] gcnt1,
   output logic [STAT_W-1:0] ccnt
`endif
);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic own_req, oth_req, keep, pick1, any;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end
   // an idle cycle keeps the owner but restarts its burst count
   always_comb begin
      state_n = gnt0 ? OWN0 : gnt1 ? OWN1 : state;
      cnt_n   = !(gnt0 || gnt1) ? '0 : state_n != state ? CW'(1) : cnt == MAXC ? cnt : cnt + 1'b1;
   end
   always_comb begin
      own_req = state == OWN0 ? req0 : req1;
      oth_req = state == OWN0 ? req1 : req0;
      keep    = state != IDLE && own_req && (cnt < MAXC || !oth_req);
      pick1   = state == IDLE ? !req0 && req1 : keep ? state == OWN1 : oth_req && state == OWN0;
      any     = (req0 || req1) && !reset;
      gnt0    = any && !pick1;
      gnt1    = any && pick1;
   end
   assign dm_addr = gnt1 ? addr1 : addr0;
   assign dm_wd   = gnt1 ? wdata1 : wdata0;
   assign dm_we   = (gnt0 && we0) || (gnt1 && we1);
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= gnt0 && !we0;
         rvalid1 <= gnt1 && !we1;
         if (gnt0 && !we0) rdata0 <= dm_rd;
         if (gnt1 && !we1) rdata1 <= dm_rd;
      end
   end
`ifdef DM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         gcnt0 <= '0;
         gcnt1 <= '0;
         ccnt  <= '0;
      end else begin
         gcnt0 <= gcnt0 + STAT_W'(gnt0 && !(&gcnt0));
         gcnt1 <= gcnt1 + STAT_W'(gnt1 && !(&gcnt1));
         ccnt  <= ccnt + STAT_W'(req0 && req1 && !(&ccnt));
      end
   end
`else
   logic [STAT_W-1:0] unused_stat;
   assign unused_stat = '0;
`endif
endmodule
